// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: merges WB-stage writes with buffered
// long-latency results, tracks pending destinations and raises decode stalls.
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lr_valid,
  output logic        lr_ready,
  input  logic [4:0]  lr_addr,
  input  logic [31:0] lr_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        stall,
  output logic        hold_wb,
  output logic        rf_wrt_ctrl,
  output logic [4:0]  rf_wrt_addr,
  output logic [31:0] rf_wrt_data
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_addr_q [2];
  logic [31:0]   fifo_data_q [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          wrt_ctrl_q, wrt_ctrl_d;
  logic [4:0]    wrt_addr_q, wrt_addr_d;
  logic [31:0]   wrt_data_q, wrt_data_d;

  logic          fifo_empty, fifo_full;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          pop, take_wb, push;

  assign fifo_empty = (count_q == 2'd0);
  assign fifo_full  = (count_q == 2'd2);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  assign hold_wb  = (starve_q == STARVE_MAX);
  assign lr_ready = ~rst & ~fifo_full;

  // A starved head pre-empts WB; otherwise WB wins and the FIFO drains in idle slots.
  assign pop     = ~fifo_empty & (hold_wb | ~wb_valid);
  assign take_wb = wb_valid & ~pop;
  assign push    = lr_valid & lr_ready & ~fifo_full & (lr_addr != 5'd0);

  assign stall = pend_q[rd_addr1] | pend_q[rd_addr2];

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};

    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    pend_d = pend_q;
    if (pop) begin
      pend_d[head_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != 5'd0)) begin
      pend_d[issue_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;

    wrt_ctrl_d = 1'b0;
    wrt_addr_d = wrt_addr_q;
    wrt_data_d = wrt_data_q;
    if (pop) begin
      wrt_ctrl_d = 1'b1;
      wrt_addr_d = head_addr;
      wrt_data_d = head_data;
    end else if (take_wb && (wb_addr != 5'd0)) begin
      wrt_ctrl_d = 1'b1;
      wrt_addr_d = wb_addr;
      wrt_data_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= '0;
      pend_q     <= '0;
      wrt_ctrl_q <= 1'b0;
      wrt_addr_q <= '0;
      wrt_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
      wrt_ctrl_q <= wrt_ctrl_d;
      wrt_addr_q <= wrt_addr_d;
      wrt_data_q <= wrt_data_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lr_addr;
      fifo_data_q[wr_ptr_q] <= lr_data;
    end
  end

  assign rf_wrt_ctrl = wrt_ctrl_q;
  assign rf_wrt_addr = wrt_addr_q;
  assign rf_wrt_data = wrt_data_q;

endmodule
